// File: rtl/dwa_element_selector.sv
// DWA unit-element selector: rotating-pointer thermometer fill with a one-deep valid/ready output register.
// Optional bidirectional rotation is enabled by defining DWA_BIDIR_EN.
module dwa_element_selector #(
    parameter  int unsigned NUM_ELEM = 16,
    localparam int unsigned PTR_W    = $clog2(NUM_ELEM),
    localparam int unsigned CNT_W    = PTR_W + 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic [CNT_W-1:0]    count_i,
    output logic                ready_o,
    output logic [NUM_ELEM-1:0] elem_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [PTR_W-1:0]    ptr_o,
    output logic                sat_o
);

    logic [NUM_ELEM-1:0] r_elem;
    logic                r_valid;
    logic [PTR_W-1:0]    r_ptr;
    logic                r_sat;
`ifdef DWA_BIDIR_EN
    logic                r_dir;
`endif

    logic                w_accept;
    logic                w_sat;
    logic [CNT_W-1:0]    w_n;
    logic [NUM_ELEM-1:0] w_elem;
    logic [PTR_W-1:0]    w_ptr_nxt;

    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;
    assign w_sat    = count_i > CNT_W'(NUM_ELEM);
    assign w_n      = w_sat ? CNT_W'(NUM_ELEM) : count_i;

    // Element k is on when its distance from the pointer (in fill direction) is below n.
    // n = NUM_ELEM truncates to 0 in the pointer add, so the pointer holds for a full fill.
    always_comb begin
        w_elem    = '0;
        w_ptr_nxt = r_ptr + PTR_W'(w_n);
        for (int k = 0; k < NUM_ELEM; k++) begin
            w_elem[k] = {1'b0, PTR_W'(PTR_W'(k) - r_ptr)} < w_n;
        end
`ifdef DWA_BIDIR_EN
        if (r_dir) begin
            w_ptr_nxt = r_ptr - PTR_W'(w_n);
            for (int k = 0; k < NUM_ELEM; k++) begin
                w_elem[k] = {1'b0, PTR_W'(r_ptr - PTR_W'(k) - PTR_W'(1))} < w_n;
            end
        end
`endif
    end

    // Output stage: load on accept, otherwise drop valid once drained; elem holds its value.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_elem  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_sat   <= 1'b0;
`ifdef DWA_BIDIR_EN
            r_dir   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_elem  <= w_elem;
            r_valid <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_sat   <= w_sat;
`ifdef DWA_BIDIR_EN
            r_dir   <= !r_dir;
`endif
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign elem_o  = r_elem;
    assign valid_o = r_valid;
    assign ptr_o   = r_ptr;
    assign sat_o   = r_sat;

endmodule

// File: tb/tb_dwa_element_selector.sv
// Directed self-checking bench for dwa_element_selector with NUM_ELEM = 16.
module tb_dwa_element_selector;

    logic        clk_i   = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [4:0]  count_i = '0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic [15:0] elem_o;
    logic        valid_o;
    logic [3:0]  ptr_o;
    logic        sat_o;

    int n_vec = 0;
    int n_err = 0;

    dwa_element_selector #(.NUM_ELEM(16)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .count_i (count_i),
        .ready_o (ready_o),
        .elem_o  (elem_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ptr_o   (ptr_o),
        .sat_o   (sat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        cyc();
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #1;
        n_vec++;
        if (elem_o !== 16'h0000 || valid_o !== 1'b0 || ptr_o !== 4'd0 || sat_o !== 1'b0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset: elem=%h valid=%b ptr=%0d sat=%b ready=%b, want 0000 0 0 0 1",
                     elem_o, valid_o, ptr_o, sat_o, ready_o);
        end
        cyc();
        reset_i = 1'b0;
    endtask

    task automatic test_forward_fill();
        logic [15:0] exp_elem [4];
        logic [3:0]  exp_ptr  [4];
        exp_elem = '{16'h001F, 16'h03E0, 16'h7C00, 16'h800F};
        exp_ptr  = '{4'd5, 4'd10, 4'd15, 4'd4};
        valid_i = 1'b1;
        count_i = 5'd5;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (elem_o !== exp_elem[i] || ptr_o !== exp_ptr[i] || valid_o !== 1'b1 || sat_o !== 1'b0) begin
                n_err++;
                $display("FAIL fwd%0d: elem=%h ptr=%0d valid=%b sat=%b, want %h %0d 1 0",
                         i, elem_o, ptr_o, valid_o, sat_o, exp_elem[i], exp_ptr[i]);
            end
        end
        valid_i = 1'b0;
        cyc();
        n_vec++;
        if (valid_o !== 1'b0 || elem_o !== 16'h800F || ptr_o !== 4'd4) begin
            n_err++;
            $display("FAIL drain: valid=%b elem=%h ptr=%0d, want 0 800f 4", valid_o, elem_o, ptr_o);
        end
    endtask

    task automatic test_zero_full();
        valid_i = 1'b1;
        count_i = 5'd0;
        cyc();
        n_vec++;
        if (elem_o !== 16'h0000 || ptr_o !== 4'd4 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL zero: elem=%h ptr=%0d valid=%b, want 0000 4 1", elem_o, ptr_o, valid_o);
        end
        count_i = 5'd16;
        cyc();
        n_vec++;
        if (elem_o !== 16'hFFFF || ptr_o !== 4'd4 || sat_o !== 1'b0) begin
            n_err++;
            $display("FAIL full: elem=%h ptr=%0d sat=%b, want ffff 4 0", elem_o, ptr_o, sat_o);
        end
    endtask

    task automatic test_saturation();
        count_i = 5'd20;
        cyc();
        n_vec++;
        if (elem_o !== 16'hFFFF || ptr_o !== 4'd4 || sat_o !== 1'b1) begin
            n_err++;
            $display("FAIL sat: elem=%h ptr=%0d sat=%b, want ffff 4 1", elem_o, ptr_o, sat_o);
        end
        count_i = 5'd2;
        cyc();
        n_vec++;
        if (elem_o !== 16'h0030 || ptr_o !== 4'd6 || sat_o !== 1'b0) begin
            n_err++;
            $display("FAIL after_sat: elem=%h ptr=%0d sat=%b, want 0030 6 0", elem_o, ptr_o, sat_o);
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        count_i = 5'd3;
        #1;
        n_vec++;
        if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ready: ready_o=%b, want 0", ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++;
            if (elem_o !== 16'h0030 || ptr_o !== 4'd6 || valid_o !== 1'b1 || ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: elem=%h ptr=%0d valid=%b ready=%b, want 0030 6 1 0",
                         i, elem_o, ptr_o, valid_o, ready_o);
            end
        end
        ready_i = 1'b1;
        #1;
        n_vec++;
        if (ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: ready_o=%b, want 1", ready_o);
        end
        cyc();
        n_vec++;
        if (elem_o !== 16'h01C0 || ptr_o !== 4'd9 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: elem=%h ptr=%0d valid=%b, want 01c0 9 1", elem_o, ptr_o, valid_o);
        end
        valid_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midop();
        do_reset();
        valid_i = 1'b1;
        count_i = 5'd7;
        cyc();
        n_vec++;
        if (elem_o !== 16'h007F || ptr_o !== 4'd7) begin
            n_err++;
            $display("FAIL pre_rst: elem=%h ptr=%0d, want 007f 7", elem_o, ptr_o);
        end
        valid_i = 1'b0;
        #3 reset_i = 1'b1;
        #1;
        n_vec++;
        if (elem_o !== 16'h0000 || valid_o !== 1'b0 || ptr_o !== 4'd0 || ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL midop_rst: elem=%h valid=%b ptr=%0d ready=%b, want 0000 0 0 1",
                     elem_o, valid_o, ptr_o, ready_o);
        end
        #1 reset_i = 1'b0;
        valid_i = 1'b1;
        count_i = 5'd3;
        cyc();
        n_vec++;
        if (elem_o !== 16'h0007 || ptr_o !== 4'd3 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst: elem=%h ptr=%0d valid=%b, want 0007 3 1", elem_o, ptr_o, valid_o);
        end
        valid_i = 1'b0;
        cyc();
    endtask

    task automatic test_bidir();
        logic [4:0]  cnt      [5];
        logic [15:0] exp_elem [5];
        logic [3:0]  exp_ptr  [5];
        logic        exp_sat  [5];
        cnt      = '{5'd3, 5'd5, 5'd4, 5'd20, 5'd0};
        exp_elem = '{16'h0007, 16'hC007, 16'hC003, 16'hFFFF, 16'h0000};
        exp_ptr  = '{4'd3, 4'd14, 4'd2, 4'd2, 4'd2};
        exp_sat  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            count_i = cnt[i];
            cyc();
            n_vec++;
            if (elem_o !== exp_elem[i] || ptr_o !== exp_ptr[i] || sat_o !== exp_sat[i] || valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL bidir%0d: elem=%h ptr=%0d sat=%b valid=%b, want %h %0d %b 1",
                         i, elem_o, ptr_o, sat_o, valid_o, exp_elem[i], exp_ptr[i], exp_sat[i]);
            end
        end
        valid_i = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
`ifdef DWA_BIDIR_EN
        test_bidir();
        test_reset_midop();
`else
        test_forward_fill();
        test_zero_full();
        test_saturation();
        test_backpressure();
        test_reset_midop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
